// File: rtl/spi_reg_bank_if.sv
// SPI target pins for spi_reg_bank: mode-0 sclk, copi, active-low ncs, cipo.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (
    output sclk,
    output copi,
    output ncs,
    input  cipo
  );

  modport slave (
    input  sclk,
    input  copi,
    input  ncs,
    output cipo
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-written bank of five 8-bit control registers (16-bit frames, MSB first).
// Define SPI_READBACK_EN to return the addressed register on cipo for read frames.
module spi_reg_bank (
  input  logic           clk,
  input  logic           rst,
  spi_reg_bank_if.slave  spi,
  output logic [7:0]     en_reg_out_7_0,
  output logic [7:0]     en_reg_out_15_8,
  output logic [7:0]     en_reg_pwm_7_0,
  output logic [7:0]     en_reg_pwm_15_8,
  output logic [7:0]     pwm_duty_cycle
);

  typedef enum logic [1:0] {
    ARM, IDLE, SHIFT, OVERRUN
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sclk_s;
  logic [1:0]  r_copi_s;
  logic [2:0]  r_ncs_s;
  logic [1:0]  r_arm_cnt;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_reg0;
  logic [7:0]  r_reg1;
  logic [7:0]  r_reg2;
  logic [7:0]  r_reg3;
  logic [7:0]  r_reg4;

  logic w_ncs;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_commit;

  assign w_ncs       = r_ncs_s[1];
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_ncs_fall  = ~r_ncs_s[1] & r_ncs_s[2];
  assign w_ncs_rise  = r_ncs_s[1] & ~r_ncs_s[2];
  assign w_commit    = (r_cnt == 5'd16) && r_shift[15]
                     && (r_shift[14:8] <= 7'd4);

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARM;
      r_sclk_s  <= 3'b000;
      r_copi_s  <= 2'b00;
      r_ncs_s   <= 3'b111;
      r_arm_cnt <= 2'd0;
      r_cnt     <= 5'd0;
      r_shift   <= 16'h0000;
      r_reg0    <= 8'h00;
      r_reg1    <= 8'h00;
      r_reg2    <= 8'h00;
      r_reg3    <= 8'h00;
      r_reg4    <= 8'h00;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi.sclk};
      r_copi_s <= {r_copi_s[0], spi.copi};
      r_ncs_s  <= {r_ncs_s[1:0], spi.ncs};
      case (r_state)
        // Flush the reset-preset synchronizer before trusting ncs high.
        ARM: begin
          if (r_arm_cnt != 2'd3)
            r_arm_cnt <= r_arm_cnt + 2'd1;
          else if (w_ncs)
            r_state <= IDLE;
        end
        IDLE: begin
          if (w_ncs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= 5'd0;
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            r_state <= IDLE;
            if (w_commit) begin
              case (r_shift[10:8])
                3'd0:    r_reg0 <= r_shift[7:0];
                3'd1:    r_reg1 <= r_shift[7:0];
                3'd2:    r_reg2 <= r_shift[7:0];
                3'd3:    r_reg3 <= r_shift[7:0];
                3'd4:    r_reg4 <= r_shift[7:0];
                default: ;
              endcase
            end
          end else if (w_sclk_rise && !w_ncs) begin
            if (r_cnt == 5'd16) begin
              r_state <= OVERRUN;
            end else begin
              r_shift <= {r_shift[14:0], r_copi_s[1]};
              r_cnt   <= r_cnt + 5'd1;
            end
          end
        end
        OVERRUN: begin
          if (w_ncs_rise)
            r_state <= IDLE;
        end
        default: r_state <= ARM;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       w_sclk_fall;
  logic       w_rd_ok;
  logic [7:0] w_rd_sel;
  logic       r_cipo;
  logic [7:0] r_rd;

  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_rd_ok     = ~r_shift[7] && (r_shift[6:0] <= 7'd4);
  assign spi.cipo    = r_cipo;

  always_comb begin
    w_rd_sel = 8'h00;
    case (r_shift[2:0])
      3'd0:    w_rd_sel = r_reg0;
      3'd1:    w_rd_sel = r_reg1;
      3'd2:    w_rd_sel = r_reg2;
      3'd3:    w_rd_sel = r_reg3;
      3'd4:    w_rd_sel = r_reg4;
      default: w_rd_sel = 8'h00;
    endcase
  end

  // Header byte is complete after rising edge 8; data leaves on falls 8..15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cipo <= 1'b0;
      r_rd   <= 8'h00;
    end else if (r_state != SHIFT || w_ncs) begin
      r_cipo <= 1'b0;
      r_rd   <= 8'h00;
    end else if (w_sclk_fall) begin
      if (r_cnt == 5'd8) begin
        r_cipo <= w_rd_ok & w_rd_sel[7];
        r_rd   <= w_rd_ok ? {w_rd_sel[6:0], 1'b0} : 8'h00;
      end else if (r_cnt > 5'd8 && r_cnt < 5'd16) begin
        r_cipo <= r_rd[7];
        r_rd   <= {r_rd[6:0], 1'b0};
      end else begin
        r_cipo <= 1'b0;
      end
    end
  end
`else
  assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, discards, reset abort, readback.
module tb_spi_reg_bank;
  logic clk;
  logic rst;
  logic [7:0] out_lo;
  logic [7:0] out_hi;
  logic [7:0] pwm_lo;
  logic [7:0] pwm_hi;
  logic [7:0] duty;
  logic [15:0] rx_cap;
  int n_chk;
  int n_err;

  spi_reg_bank_if spi ();

  spi_reg_bank dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi.slave),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [39:0] w_all = {out_lo, out_hi, pwm_lo, pwm_hi, duty};

  task automatic chk(input string tag,
                     input logic [39:0] got,
                     input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bits(input logic [15:0] w,
                      input int first,
                      input int last);
    for (int i = first; i <= last; i++) begin
      spi.copi = 1'b0;
      if (i < 16) spi.copi = w[4'(15 - i)];
      #50;
      rx_cap = {rx_cap[14:0], spi.cipo};
      spi.sclk = 1'b1;
      #50;
      spi.sclk = 1'b0;
    end
  endtask

  // Leaves ncs just raised on a falling clk edge.
  task automatic xfer(input logic [15:0] w, input int nbits);
    @(negedge clk);
    rx_cap   = 16'h0000;
    spi.ncs  = 1'b0;
    bits(w, 0, nbits - 1);
    #50;
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (6) @(posedge clk);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rx_cap   = 16'h0000;
    rst      = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_regs", w_all, 40'h0);
    chk("rst_cipo", {39'h0, spi.cipo}, 40'h0);
    @(negedge clk);
    rst = 1'b0;
    gap();

    xfer(16'h80FF, 16);
    repeat (2) @(posedge clk);
    #1;
    chk("wr00_early", {32'h0, out_lo}, 40'h00);
    @(posedge clk);
    #1;
    chk("wr00_lat3", {32'h0, out_lo}, 40'hFF);
    chk("wr00_all", w_all, 40'hFF_00_00_00_00);
    gap();

    xfer(16'h8480, 16);
    settle();
    chk("wr04_duty", {32'h0, duty}, 40'h80);
    gap();
    xfer(16'h8301, 16);
    settle();
    chk("wr03_all", w_all, 40'hFF_00_00_01_80);
    gap();

    xfer(16'h8755, 16);
    settle();
    chk("bad_addr", w_all, 40'hFF_00_00_01_80);
    gap();
    xfer(16'h8211, 15);
    settle();
    chk("short15", w_all, 40'hFF_00_00_01_80);
    gap();
    xfer(16'h8222, 17);
    settle();
    chk("over17", w_all, 40'hFF_00_00_01_80);
    gap();

    xfer(16'h84C3, 16);
    settle();
    chk("wr04_c3", w_all, 40'hFF_00_00_01_C3);
    gap();
    xfer(16'h0400, 16);
    settle();
`ifdef SPI_READBACK_EN
    chk("rd04_cipo", {24'h0, rx_cap}, 40'h00C3);
`else
    chk("rd04_cipo", {24'h0, rx_cap}, 40'h0000);
`endif
    chk("rd04_regs", w_all, 40'hFF_00_00_01_C3);
    chk("idle_cipo", {39'h0, spi.cipo}, 40'h0);
    gap();

    @(negedge clk);
    rx_cap  = 16'h0000;
    spi.ncs = 1'b0;
    bits(16'h8055, 0, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bits(16'h8055, 9, 15);
    #50;
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    settle();
    chk("rst_abort", w_all, 40'h0);
    gap();
    xfer(16'h81AA, 16);
    settle();
    chk("post_rst_wr", w_all, 40'h00_AA_00_00_00);
    gap();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
